// File: rtl/ldpc_sched_pkg.sv
// Shared types and constants for the LDPC iteration scheduler.
// Holds the scheduler state encoding, default geometry and the VN pipeline depth.
// No logic; imported by the interface, the index pipe and the top level.
package ldpc_sched_pkg;

  localparam int N_VN_DEFAULT = 20;
  localparam int AW_DEFAULT   = 5;

  // Read-to-write-back distance in the VN unit; also the length of VN_DRAIN.
  localparam int VN_PIPE = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VN,
    S_VN_DRAIN,
    S_CN,
    S_CN_WAIT,
    S_CHK,
    S_DONE
  } state_t;

endpackage

// File: rtl/ldpc_iter_sched_if.sv
// Bundle of all scheduler-facing signals: host stream, RAM port, VN/CN strobes, status.
// slave  : the scheduler side (takes decode/llr_valid/ok_n, drives everything else).
// master : the environment side (host, RAM, VN unit and check-node array).
interface ldpc_iter_sched_if
  import ldpc_sched_pkg::*;
#(
  parameter int AW = AW_DEFAULT
);

  logic          decode;
  logic          llr_valid;
  logic          llr_ready;
  logic          ok_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic          re;
  logic [AW-1:0] raddr;
  logic          vn_en;
  logic [AW-1:0] number;
  logic          cn_en;
  logic [AW-1:0] times;
  logic          busy;
  logic          done;
  logic          success;

  modport slave (
    input  decode, llr_valid, ok_n,
    output llr_ready, we, waddr, re, raddr, vn_en, number,
           cn_en, times, busy, done, success
  );

  modport master (
    output decode, llr_valid, ok_n,
    input  llr_ready, we, waddr, re, raddr, vn_en, number,
           cn_en, times, busy, done, success
  );

endinterface

// File: rtl/ldpc_idx_pipe.sv
// Shift register carrying {valid, index} alongside the VN unit datapath.
// Latency: tap k shows the input k cycles later (tap 1 = update strobe, tap DEPTH = write-back).
// No backpressure: shifts every cycle, cleared by synchronous rst.
// Ports: clk, rst, in_vld/in_idx (read issue), tap_vld/tap_idx (per-stage outputs, 1..DEPTH).
module ldpc_idx_pipe #(
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [AW-1:0]         in_idx,
  output logic [DEPTH:1]        tap_vld,
  output logic [DEPTH:1][AW-1:0] tap_idx
);

  // Index is zeroed when not valid so downstream address outputs idle at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_vld <= '0;
      tap_idx <= '0;
    end else begin
      tap_vld[1] <= in_vld;
      tap_idx[1] <= in_vld ? in_idx : '0;
      for (int i = 2; i <= DEPTH; i++) begin
        tap_vld[i] <= tap_vld[i-1];
        tap_idx[i] <= tap_idx[i-1];
      end
    end
  end

endmodule

// File: rtl/ldpc_iter_sched.sv
// Iteration scheduler: loads channel LLRs, then alternates VN sweeps and CN checks until done.
// Latency: N_VN load beats, then N_VN + VN_PIPE + 1 + CN_LAT + 1 cycles per iteration.
// Backpressure: llr_ready is high for all of LOAD; gaps in llr_valid stall the load only.
// Ports: clk, rst (sync, active high), bus (ldpc_iter_sched_if.slave).
// Optional feature: LDPC_EARLY_STOP_EN stops at the first CHK that sees ok_n = 0.
module ldpc_iter_sched
  import ldpc_sched_pkg::*;
#(
  parameter int N_VN     = N_VN_DEFAULT,
  parameter int AW       = AW_DEFAULT,
  parameter int MAX_ITER = 8,
  parameter int CN_LAT   = 2
) (
  input logic                  clk,
  input logic                  rst,
  ldpc_iter_sched_if.slave     bus
);

  localparam logic [AW-1:0] IDX_LAST   = AW'(N_VN - 1);
  localparam logic [7:0]    DRAIN_LAST = 8'(VN_PIPE - 1);
  localparam logic [7:0]    WAIT_LAST  = 8'(CN_LAT - 1);
  localparam logic [AW-1:0] ITER_LAST  = AW'(MAX_ITER);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [AW-1:0] times_q, times_d;
  logic          success_q, success_d;

  logic          load_we;
  logic          rd_en;
  logic          cn_pulse;
  logic          done_pulse;
  logic [AW-1:0] times_inc;

  logic [VN_PIPE:1]         pipe_vld;
  logic [VN_PIPE:1][AW-1:0] pipe_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wcnt_q    <= '0;
      times_q   <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      times_q   <= times_d;
      success_q <= success_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    times_d    = times_q;
    success_d  = success_q;
    load_we    = 1'b0;
    rd_en      = 1'b0;
    cn_pulse   = 1'b0;
    done_pulse = 1'b0;
    times_inc  = times_q + AW'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.decode) begin
          state_d   = S_LOAD;
          idx_d     = '0;
          times_d   = '0;
          success_d = 1'b0;
        end
      end

      S_LOAD: begin
        if (bus.llr_valid) begin
          load_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_VN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end

      // idx is left at its last value on exit; the next sweep reloads it.
      S_VN: begin
        rd_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_VN_DRAIN;
          wcnt_d  = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end

      S_VN_DRAIN: begin
        if (wcnt_q == DRAIN_LAST) begin
          state_d = S_CN;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      S_CN: begin
        cn_pulse = 1'b1;
        state_d  = S_CN_WAIT;
        wcnt_d   = '0;
      end

      S_CN_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = S_CHK;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      S_CHK: begin
        times_d = times_inc;
`ifdef LDPC_EARLY_STOP_EN
        if (!bus.ok_n) begin
          state_d   = S_DONE;
          success_d = 1'b1;
        end else if (times_inc == ITER_LAST) begin
          state_d   = S_DONE;
          success_d = ~bus.ok_n;
        end else begin
          state_d = S_VN;
          idx_d   = '0;
        end
`else
        if (times_inc == ITER_LAST) begin
          state_d   = S_DONE;
          success_d = ~bus.ok_n;
        end else begin
          state_d = S_VN;
          idx_d   = '0;
        end
`endif
      end

      S_DONE: begin
        done_pulse = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  ldpc_idx_pipe #(
    .DEPTH (VN_PIPE),
    .AW    (AW)
  ) u_idx_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_en),
    .in_idx  (idx_q),
    .tap_vld (pipe_vld),
    .tap_idx (pipe_idx)
  );

  // Load writes and write-backs never overlap: the pipe is empty during LOAD.
  assign bus.we        = load_we | pipe_vld[VN_PIPE];
  assign bus.waddr     = load_we ? idx_q : pipe_idx[VN_PIPE];
  assign bus.re        = rd_en;
  assign bus.raddr     = rd_en ? idx_q : '0;
  assign bus.vn_en     = pipe_vld[1];
  assign bus.number    = pipe_idx[1];
  assign bus.cn_en     = cn_pulse;
  assign bus.llr_ready = (state_q == S_LOAD);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_pulse;
  assign bus.times     = times_q;
  assign bus.success   = success_q;

endmodule

// File: tb/tb_ldpc_iter_sched.sv
// Directed bench for ldpc_iter_sched: table-driven cycle checks plus hand-written sequences.
module tb_ldpc_iter_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldpc_iter_sched_if #(.AW(5)) bus();

  ldpc_iter_sched #(
    .N_VN     (20),
    .AW       (5),
    .MAX_ITER (8),
    .CN_LAT   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef LDPC_EARLY_STOP_EN
  localparam int R2_DONE  = 65;
  localparam int R2_TIMES = 1;
`else
  localparam int R2_DONE  = 247;
  localparam int R2_TIMES = 8;
`endif

  typedef struct packed {
    logic       busy;
    logic       rdy;
    logic       we;
    logic [4:0] waddr;
    logic       re;
    logic [4:0] raddr;
    logic       vn_en;
    logic [4:0] number;
    logic       cn_en;
    logic       done;
    logic       success;
    logic [4:0] times;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic obs_t mk(bit b, bit r, bit w, int wa, bit rd, int ra,
                              bit v, int n, bit c, bit d, bit s, int t);
    obs_t o;
    o.busy = b; o.rdy = r; o.we = w; o.waddr = 5'(wa);
    o.re = rd; o.raddr = 5'(ra); o.vn_en = v; o.number = 5'(n);
    o.cn_en = c; o.done = d; o.success = s; o.times = 5'(t);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = bus.busy; o.rdy = bus.llr_ready; o.we = bus.we; o.waddr = bus.waddr;
    o.re = bus.re; o.raddr = bus.raddr; o.vn_en = bus.vn_en; o.number = bus.number;
    o.cn_en = bus.cn_en; o.done = bus.done; o.success = bus.success; o.times = bus.times;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.decode = 1'b0;
    bus.llr_valid = 1'b0;
    bus.ok_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[17];
  obs_t o;
  int ti, cn_cnt, first_cn, last_cn, bad_gap, done_cnt, done_cyc, we_cnt, re_cnt;
  int wr_cnt, ld_cyc, addr_err, gap_err, first_re;
  logic [4:0] done_times;
  logic done_succ;

  initial begin
    rst = 1'b1;
    bus.decode = 1'b0;
    bus.llr_valid = 1'b0;
    bus.ok_n = 1'b1;

    // Cycle 0 = first LOAD cycle after decode is accepted.
    tbl[0]  = '{cyc: 0,   exp: mk(1,1,1,0,  0,0, 0,0, 0,0,0,0)};
    tbl[1]  = '{cyc: 5,   exp: mk(1,1,1,5,  0,0, 0,0, 0,0,0,0)};
    tbl[2]  = '{cyc: 19,  exp: mk(1,1,1,19, 0,0, 0,0, 0,0,0,0)};
    tbl[3]  = '{cyc: 20,  exp: mk(1,0,0,0,  1,0, 0,0, 0,0,0,0)};
    tbl[4]  = '{cyc: 21,  exp: mk(1,0,0,0,  1,1, 1,0, 0,0,0,0)};
    tbl[5]  = '{cyc: 22,  exp: mk(1,0,1,0,  1,2, 1,1, 0,0,0,0)};
    tbl[6]  = '{cyc: 39,  exp: mk(1,0,1,17, 1,19,1,18,0,0,0,0)};
    tbl[7]  = '{cyc: 40,  exp: mk(1,0,1,18, 0,0, 1,19,0,0,0,0)};
    tbl[8]  = '{cyc: 41,  exp: mk(1,0,1,19, 0,0, 0,0, 0,0,0,0)};
    tbl[9]  = '{cyc: 42,  exp: mk(1,0,0,0,  0,0, 0,0, 1,0,0,0)};
    tbl[10] = '{cyc: 45,  exp: mk(1,0,0,0,  0,0, 0,0, 0,0,0,0)};
    tbl[11] = '{cyc: 46,  exp: mk(1,0,0,0,  1,0, 0,0, 0,0,0,1)};
    tbl[12] = '{cyc: 68,  exp: mk(1,0,0,0,  0,0, 0,0, 1,0,0,1)};
    tbl[13] = '{cyc: 227, exp: mk(1,0,0,0,  0,0, 0,0, 0,0,0,7)};
    tbl[14] = '{cyc: 228, exp: mk(1,0,0,0,  0,0, 0,0, 0,1,0,8)};
    tbl[15] = '{cyc: 229, exp: mk(0,0,0,0,  0,0, 0,0, 0,0,0,8)};
    tbl[16] = '{cyc: 230, exp: mk(1,1,1,0,  0,0, 0,0, 0,0,0,0)};

    do_reset();
    #1;
    chk("reset_state", 64'(sample()), 64'(0));

    // Run 1: continuous load, ok_n = 1, decode held high the whole time.
    bus.decode = 1'b1;
    bus.llr_valid = 1'b1;
    bus.ok_n = 1'b1;
    ti = 0; cn_cnt = 0; first_cn = -1; last_cn = -1; bad_gap = 0;
    done_cnt = 0; done_cyc = -1; we_cnt = 0; re_cnt = 0;
    for (int cyc = 0; cyc <= 230; cyc++) begin
      @(negedge clk);
      #1;
      o = sample();
      if (ti < 17 && tbl[ti].cyc == cyc) begin
        chk($sformatf("run1_cyc%0d", cyc), 64'(o), 64'(tbl[ti].exp));
        ti++;
      end
      if (cyc <= 229) begin
        if (o.cn_en) begin
          cn_cnt++;
          if (last_cn >= 0 && cyc - last_cn != 26) bad_gap++;
          if (first_cn < 0) first_cn = cyc;
          last_cn = cyc;
        end
        if (o.done) begin done_cnt++; done_cyc = cyc; end
        if (o.we) we_cnt++;
        if (o.re) re_cnt++;
      end
    end
    chk("run1_table_visited", 64'(ti), 64'(17));
    chk("run1_cn_count", 64'(cn_cnt), 64'(8));
    chk("run1_first_cn", 64'(first_cn), 64'(42));
    chk("run1_last_cn", 64'(last_cn), 64'(224));
    chk("run1_cn_spacing_errs", 64'(bad_gap), 64'(0));
    chk("run1_done_count", 64'(done_cnt), 64'(1));
    chk("run1_done_cycle", 64'(done_cyc), 64'(228));
    chk("run1_write_count", 64'(we_cnt), 64'(180));
    chk("run1_read_count", 64'(re_cnt), 64'(160));

    // Run 2: llr_valid toggling 1/0 during load, ok_n = 0 throughout.
    do_reset();
    bus.decode = 1'b1;
    bus.ok_n = 1'b0;
    wr_cnt = 0; ld_cyc = 0; addr_err = 0; gap_err = 0; first_re = -1;
    done_cnt = 0; done_cyc = -1; done_times = '0; done_succ = 1'b0;
    for (int cyc = 0; cyc < 260; cyc++) begin
      @(negedge clk);
      bus.decode = 1'b0;
      bus.llr_valid = (cyc % 2 == 0);
      #1;
      o = sample();
      if (o.rdy) begin
        ld_cyc++;
        if (o.we !== bus.llr_valid) gap_err++;
        if (o.we) begin
          if (int'(o.waddr) != wr_cnt) addr_err++;
          wr_cnt++;
        end
      end
      if (o.re && first_re < 0) first_re = cyc;
      if (o.done) begin
        done_cnt++; done_cyc = cyc; done_times = o.times; done_succ = o.success;
      end
    end
    chk("run2_load_writes", 64'(wr_cnt), 64'(20));
    chk("run2_load_cycles", 64'(ld_cyc), 64'(39));
    chk("run2_addr_errs", 64'(addr_err), 64'(0));
    chk("run2_gap_errs", 64'(gap_err), 64'(0));
    chk("run2_first_read", 64'(first_re), 64'(39));
    chk("run2_done_count", 64'(done_cnt), 64'(1));
    chk("run2_done_cycle", 64'(done_cyc), 64'(R2_DONE));
    chk("run2_times", 64'(done_times), 64'(R2_TIMES));
    chk("run2_success", 64'(done_succ), 64'(1));
    chk("run2_idle_held", 64'({o.busy, o.success, o.times}), 64'({1'b0, 1'b1, 5'(R2_TIMES)}));

    // Run 3: reset during the third VN sweep, then restart.
    do_reset();
    bus.decode = 1'b1;
    bus.llr_valid = 1'b1;
    bus.ok_n = 1'b1;
    done_cnt = 0;
    for (int cyc = 0; cyc <= 82; cyc++) begin
      @(negedge clk);
      bus.decode = (cyc == 81);
      rst = (cyc == 80);
      #1;
      o = sample();
      if (o.done) done_cnt++;
      if (cyc == 80) chk("run3_pre_reset", 64'(o), 64'(mk(1,0,1,6, 1,8, 1,7, 0,0,0,2)));
      if (cyc == 81) chk("run3_after_reset", 64'(o), 64'(0));
      if (cyc == 82) chk("run3_restart", 64'(o), 64'(mk(1,1,1,0, 0,0, 0,0, 0,0,0,0)));
    end
    chk("run3_no_done", 64'(done_cnt), 64'(0));

    bus.decode = 1'b0;
    bus.llr_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
